stage_decode_pipelined: RTL and testbench

Parametrised instruction-decode stage for the RISC-V core. It holds the register file, an N-source forwarding mux and the branch-decision logic. It owns the ID/EX pipeline register, with a valid/ready handshake, load-use stall insertion, flush and a stall-cycle counter. It sits between the IF/ID register and the execute stage. Immediate generation stays in the existing `immediate_gen`, which feeds this block.

---
 rtl/stage_decode_pipelined.sv | 221 ++++++++++++++++++++++
 tb/tb_stage_decode_pipelined.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_decode_pipelined.sv
// Instruction-decode stage: register file, operand forwarding, branch decision and the
// ID/EX pipeline register with valid/ready handshake, load-use stall and flush.
module stage_decode_pipelined #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_FWD  = 3,
  localparam int unsigned RW      = $clog2(NUM_REGS),
  localparam int unsigned SW      = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc,
  input  logic [31:0]             instruction,
  input  logic [XLEN-1:0]         immediate,
  input  logic [2:0]              branch_type,
  input  logic [SW-1:0]           fwd_sel_1,
  input  logic [SW-1:0]           fwd_sel_2,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_pc,
  output logic [4:0]              out_rd,
  output logic                    branch_taken,
  output logic [XLEN-1:0]         branch_target,
  output logic [31:0]             stall_count
);

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrEq   = 3'd1,
    BrNe   = 3'd2,
    BrLt   = 3'd3,
    BrGe   = 3'd4,
    BrLtu  = 3'd5,
    BrGeu  = 3'd6,
    BrAlways = 3'd7
  } br_type_e;

  // Instruction fields
  logic [4:0]    rs1_f;
  logic [4:0]    rs2_f;
  logic [4:0]    rd_f;
  logic [RW-1:0] rs1_idx;
  logic [RW-1:0] rs2_idx;
  logic [RW-1:0] wr_idx;
  logic          unused_instr;

  assign rs1_f        = instruction[19:15];
  assign rs2_f        = instruction[24:20];
  assign rd_f         = instruction[11:7];
  assign rs1_idx      = rs1_f[RW-1:0];
  assign rs2_idx      = rs2_f[RW-1:0];
  assign wr_idx       = wr_addr[RW-1:0];
  assign unused_instr = ^{instruction[31:25], instruction[14:12], instruction[6:0]};

  // Register file
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic            wr_fire;

  assign wr_fire = wr_en & (wr_idx != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_fire) begin
      rf_q[wr_idx] <= wr_data;
    end
  end

  // Reads see a same-cycle write so write-back needs no separate forwarding slot.
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;

  always_comb begin
    rf_rs1 = rf_q[rs1_idx];
    if (rs1_idx == '0) begin
      rf_rs1 = '0;
    end else if (wr_fire && (wr_idx == rs1_idx)) begin
      rf_rs1 = wr_data;
    end
    rf_rs2 = rf_q[rs2_idx];
    if (rs2_idx == '0) begin
      rf_rs2 = '0;
    end else if (wr_fire && (wr_idx == rs2_idx)) begin
      rf_rs2 = wr_data;
    end
  end

  // Operand forwarding mux
  logic [XLEN-1:0] fwd_slice [NUM_FWD];
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd_slice
    assign fwd_slice[k] = fwd_data[k*XLEN +: XLEN];
  end

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (fwd_sel_1 == '0) begin
      op1 = rf_rs1;
    end
    if (fwd_sel_2 == '0) begin
      op2 = rf_rs2;
    end
    for (int k = 0; k < NUM_FWD; k++) begin
      if (fwd_sel_1 == SW'(k + 1)) begin
        op1 = fwd_slice[k];
      end
      if (fwd_sel_2 == SW'(k + 1)) begin
        op2 = fwd_slice[k];
      end
    end
  end

  // Load-use hazard; rs2 is compared regardless of format, so I-type may stall spuriously.
  logic hazard;
  logic accept;
  logic out_valid_q;

  assign hazard = in_valid & ex_is_load & (ex_rd != 5'd0) &
                  ((ex_rd == rs1_f) | (ex_rd == rs2_f));

  // Nothing is accepted while reset is held, which also keeps branch_taken low.
  assign in_ready = reset_n & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Branch decision
  logic cond;

  always_comb begin
    cond = 1'b0;
    case (br_type_e'(branch_type))
      BrNone:   cond = 1'b0;
      BrEq:     cond = (op1 == op2);
      BrNe:     cond = (op1 != op2);
      BrLt:     cond = ($signed(op1) < $signed(op2));
      BrGe:     cond = ($signed(op1) >= $signed(op2));
      BrLtu:    cond = (op1 < op2);
      BrGeu:    cond = (op1 >= op2);
      BrAlways: cond = 1'b1;
      default:  cond = 1'b0;
    endcase
  end

  assign branch_taken  = accept & cond;
  assign branch_target = pc + immediate;

  // ID/EX register
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
    end else if (accept) begin
      rs1_data_q <= op1;
      rs2_data_q <= op2;
      imm_q      <= immediate;
      pc_q       <= pc;
      rd_q       <= rd_f;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;

  // Saturating load-use stall counter
  logic [31:0] stall_q;
  logic        stall_inc;

  assign stall_inc = hazard & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_stage_decode_pipelined.sv
// Self-checking bench for stage_decode_pipelined: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_stage_decode_pipelined;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_FWD  = 3;
  localparam int unsigned SW       = 2;

  logic                    clk;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             pc;
  logic [31:0]             instruction;
  logic [31:0]             immediate;
  logic [2:0]              branch_type;
  logic [SW-1:0]           fwd_sel_1;
  logic [SW-1:0]           fwd_sel_2;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [31:0]             wr_data;
  logic                    ex_is_load;
  logic [4:0]              ex_rd;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_rs1_data;
  logic [31:0]             out_rs2_data;
  logic [31:0]             out_imm;
  logic [31:0]             out_pc;
  logic [4:0]              out_rd;
  logic                    branch_taken;
  logic [31:0]             branch_target;
  logic [31:0]             stall_count;

  int cmp_count = 0;
  int err_count = 0;

  stage_decode_pipelined #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .NUM_FWD  (NUM_FWD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pc            (pc),
    .instruction   (instruction),
    .immediate     (immediate),
    .branch_type   (branch_type),
    .fwd_sel_1     (fwd_sel_1),
    .fwd_sel_2     (fwd_sel_2),
    .fwd_data      (fwd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1_data  (out_rs1_data),
    .out_rs2_data  (out_rs2_data),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [NUM_REGS];
  logic        m_valid;
  logic [31:0] m_op1, m_op2, m_imm, m_pc;
  logic [4:0]  m_rd;
  logic [31:0] m_stall;

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic branch_ok(input logic [2:0] bt, input logic [31:0] a,
                                     input logic [31:0] b);
    case (bt)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return $signed(a) < $signed(b);
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a < b;
      3'd6:    return a >= b;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_operand(input logic [SW-1:0] sel, input logic [4:0] rs);
    if (sel != 0) return fwd_data[(int'(sel) - 1)*32 +: 32];
    if (rs == 0) return 32'd0;
    if (wr_en && wr_addr == rs) return wr_data;
    return m_regs[rs];
  endfunction

  task automatic idle();
    in_valid = 0; pc = 0; instruction = 0; immediate = 0; branch_type = 0;
    fwd_sel_1 = 0; fwd_sel_2 = 0; fwd_data = '0; wr_en = 0; wr_addr = 0; wr_data = 0;
    ex_is_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1;
    #1 reset_n = 0;
    in_valid = 1; branch_type = 3'd7;
    #1;
    cmp_count++;
    if (out_valid !== 1'b0) begin
      err_count++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    cmp_count++;
    if (stall_count !== 32'd0) begin
      err_count++; $display("FAIL reset_stall: got %h want 0", stall_count);
    end
    cmp_count++;
    if ({out_rs1_data, out_rs2_data, out_imm, out_pc, out_rd} !== '0) begin
      err_count++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0",
               out_rs1_data, out_rs2_data, out_imm, out_pc, out_rd);
    end
    cmp_count++;
    if (branch_taken !== 1'b0) begin
      err_count++; $display("FAIL reset_taken: got %b want 0", branch_taken);
    end
    step();
    idle();
    reset_n = 1;
  endtask

  task automatic test_regfile();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
    in_valid = 1; instruction = mk(5, 0, 1);
    #1;
    cmp_count++;
    if (in_ready !== 1'b1) begin
      err_count++; $display("FAIL rf_ready: got %b want 1", in_ready);
    end
    step();
    cmp_count++;
    if ({out_valid, out_rs1_data, out_rd} !== {1'b1, 32'h1234, 5'd1}) begin
      err_count++;
      $display("FAIL rf_bypass: got v=%b rs1=%h rd=%0d want v=1 rs1=1234 rd=1",
               out_valid, out_rs1_data, out_rd);
    end
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF;
    in_valid = 1; instruction = mk(0, 5, 3);
    step();
    cmp_count++;
    if ({out_rs1_data, out_rs2_data} !== {32'd0, 32'h1234}) begin
      err_count++;
      $display("FAIL rf_x0_write: got rs1=%h rs2=%h want 0 1234", out_rs1_data, out_rs2_data);
    end
    idle();
    in_valid = 1; instruction = mk(0, 0, 4);
    step();
    cmp_count++;
    if (out_rs1_data !== 32'd0) begin
      err_count++; $display("FAIL rf_x0_read: got %h want 0", out_rs1_data);
    end
    idle();
  endtask

  task automatic test_forward_branch();
    idle();
    wr_en = 1; wr_addr = 6; wr_data = 32'hDEAD_BEEF;
    step();
    idle();
    in_valid = 1; instruction = mk(3, 6, 8);
    fwd_sel_1 = 2; fwd_data[0 +: 32] = 32'h1; fwd_data[32 +: 32] = 32'hDEAD_BEEF;
    branch_type = 3'd1; pc = 32'h100; immediate = 32'h20;
    #1;
    cmp_count++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h120}) begin
      err_count++;
      $display("FAIL fwd_beq: got taken=%b tgt=%h want 1 120", branch_taken, branch_target);
    end
    branch_type = 3'd2;
    #1;
    cmp_count++;
    if (branch_taken !== 1'b0) begin
      err_count++; $display("FAIL fwd_bne: got %b want 0", branch_taken);
    end
    branch_type = 3'd1;
    step();
    cmp_count++;
    if ({out_rs1_data, out_rs2_data, out_pc, out_imm, out_rd} !==
        {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 32'h20, 5'd8}) begin
      err_count++;
      $display("FAIL fwd_latch: got %h %h %h %h %0d want deadbeef deadbeef 100 20 8",
               out_rs1_data, out_rs2_data, out_pc, out_imm, out_rd);
    end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1; ex_rd = 7;
    in_valid = 1; instruction = mk(1, 7, 2); branch_type = 3'd7;
    #1;
    cmp_count++;
    if ({in_ready, branch_taken} !== 2'b00) begin
      err_count++;
      $display("FAIL lu_block: got ready=%b taken=%b want 0 0", in_ready, branch_taken);
    end
    step();
    cmp_count++;
    if ({out_valid, stall_count} !== {1'b0, 32'd1}) begin
      err_count++;
      $display("FAIL lu_bubble: got v=%b stall=%0d want v=0 stall=1", out_valid, stall_count);
    end
    ex_is_load = 0;
    #1;
    cmp_count++;
    if ({in_ready, branch_taken} !== 2'b11) begin
      err_count++;
      $display("FAIL lu_release: got ready=%b taken=%b want 1 1", in_ready, branch_taken);
    end
    step();
    cmp_count++;
    if ({out_valid, out_rd, stall_count} !== {1'b1, 5'd2, 32'd1}) begin
      err_count++;
      $display("FAIL lu_accept: got v=%b rd=%0d stall=%0d want 1 2 1",
               out_valid, out_rd, stall_count);
    end
    idle();
  endtask

  task automatic test_signed_unsigned();
    logic [2:0] bts [4];
    logic       exp [4];
    bts = '{3'd3, 3'd5, 3'd4, 3'd6};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    idle();
    in_valid = 1; instruction = mk(1, 2, 9);
    fwd_sel_1 = 1; fwd_sel_2 = 2;
    fwd_data[0 +: 32] = 32'hFFFF_FFFF; fwd_data[32 +: 32] = 32'h1;
    pc = 32'hFFFF_FFF0; immediate = 32'h20;
    for (int i = 0; i < 4; i++) begin
      branch_type = bts[i];
      #1;
      cmp_count++;
      if (branch_taken !== exp[i]) begin
        err_count++;
        $display("FAIL cmp_type%0d: got %b want %b", bts[i], branch_taken, exp[i]);
      end
    end
    cmp_count++;
    if (branch_target !== 32'h10) begin
      err_count++; $display("FAIL target_wrap: got %h want 10", branch_target);
    end
    step();
    idle();
  endtask

  task automatic test_backpressure_flush();
    idle();
    in_valid = 1; instruction = mk(0, 0, 10); pc = 32'h200; immediate = 32'h44;
    step();
    out_ready = 0;
    instruction = mk(0, 0, 11); pc = 32'h300; immediate = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp_count++;
      if (in_ready !== 1'b0) begin
        err_count++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready);
      end
      step();
      cmp_count++;
      if ({out_valid, out_pc, out_imm, out_rd} !== {1'b1, 32'h200, 32'h44, 5'd10}) begin
        err_count++;
        $display("FAIL bp_hold%0d: got v=%b pc=%h imm=%h rd=%0d want 1 200 44 10",
                 i, out_valid, out_pc, out_imm, out_rd);
      end
    end
    flush = 1; branch_type = 3'd7;
    #1;
    cmp_count++;
    if ({branch_taken, in_ready} !== 2'b00) begin
      err_count++;
      $display("FAIL flush_comb: got taken=%b ready=%b want 0 0", branch_taken, in_ready);
    end
    step();
    cmp_count++;
    if (out_valid !== 1'b0) begin
      err_count++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_reset_midstall();
    do_reset();
    idle();
    in_valid = 1; instruction = mk(0, 0, 12); pc = 32'h400;
    step();
    out_ready = 0; ex_is_load = 1; ex_rd = 9; instruction = mk(9, 0, 13);
    repeat (5) step();
    cmp_count++;
    if ({out_valid, stall_count} !== {1'b1, 32'd5}) begin
      err_count++;
      $display("FAIL ms_setup: got v=%b stall=%0d want 1 5", out_valid, stall_count);
    end
    ex_is_load = 0; branch_type = 3'd7;
    #1 reset_n = 0;
    #1;
    cmp_count++;
    if ({out_valid, stall_count, out_rs1_data, out_rs2_data, out_imm, out_pc, out_rd,
         branch_taken} !== '0) begin
      err_count++;
      $display("FAIL ms_async: got v=%b stall=%0d pc=%h rd=%0d taken=%b want all 0",
               out_valid, stall_count, out_pc, out_rd, branch_taken);
    end
    #1 reset_n = 1;
    idle();
    in_valid = 1; instruction = mk(0, 0, 14); pc = 32'h500;
    step();
    cmp_count++;
    if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd14, 32'h500}) begin
      err_count++;
      $display("FAIL ms_resume: got v=%b rd=%0d pc=%h want 1 14 500", out_valid, out_rd, out_pc);
    end
    idle();
  endtask

  task automatic test_random();
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] e_op1, e_op2, e_target;
    logic        e_haz, e_ready, e_acc, e_taken;
    do_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 31));
      instruction = $urandom;
      instruction[19:15] = rs1; instruction[24:20] = rs2; instruction[11:7] = rd;
      in_valid    = ($urandom_range(0, 3) != 0);
      pc          = $urandom;
      immediate   = $urandom;
      branch_type = 3'($urandom_range(0, 7));
      fwd_sel_1   = SW'($urandom_range(0, NUM_FWD));
      fwd_sel_2   = SW'($urandom_range(0, NUM_FWD));
      fwd_data    = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) fwd_data[63:32] = fwd_data[31:0];
      wr_en       = ($urandom_range(0, 1) != 0);
      wr_addr     = 5'($urandom_range(0, 7));
      wr_data     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);

      e_op1    = model_operand(fwd_sel_1, rs1);
      e_op2    = model_operand(fwd_sel_2, rs2);
      e_haz    = in_valid && ex_is_load && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
      e_ready  = !flush && !e_haz && (!m_valid || out_ready);
      e_acc    = in_valid && e_ready;
      e_taken  = e_acc && branch_ok(branch_type, e_op1, e_op2);
      e_target = pc + immediate;
      #1;
      cmp_count++;
      if ({in_ready, branch_taken, branch_target} !== {e_ready, e_taken, e_target}) begin
        err_count++;
        $display("FAIL rnd_comb c%0d: got ready=%b taken=%b tgt=%h want %b %b %h", cyc,
                 in_ready, branch_taken, branch_target, e_ready, e_taken, e_target);
      end

      if (flush) m_valid = 0;
      else if (e_acc) begin
        m_valid = 1; m_op1 = e_op1; m_op2 = e_op2; m_imm = immediate; m_pc = pc; m_rd = rd;
      end else if (out_ready) m_valid = 0;
      if (e_haz && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;

      step();
      cmp_count++;
      if (out_valid !== m_valid) begin
        err_count++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, m_valid);
      end
      cmp_count++;
      if ({out_rs1_data, out_rs2_data, out_imm, out_pc, out_rd} !==
          {m_op1, m_op2, m_imm, m_pc, m_rd}) begin
        err_count++;
        $display("FAIL rnd_data c%0d: got %h %h %h %h %0d want %h %h %h %h %0d", cyc,
                 out_rs1_data, out_rs2_data, out_imm, out_pc, out_rd,
                 m_op1, m_op2, m_imm, m_pc, m_rd);
      end
      cmp_count++;
      if (stall_count !== m_stall) begin
        err_count++;
        $display("FAIL rnd_stall c%0d: got %0d want %0d", cyc, stall_count, m_stall);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_forward_branch();
    test_load_use();
    test_signed_unsigned();
    test_backpressure_flush();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
